// File: rtl/l2_mem_responder.sv
// l2_mem_responder: line-granular backing memory beneath the L2 cache.
// Accepts one read or write line request at a time and answers with a
// single-cycle mem_ready pulse a fixed number of edges after acceptance.
// It also counts accepted reads and writes and flags read+write collisions.
module l2_mem_responder #(
  parameter int LINE_W     = 128,
  parameter int ADDR_W     = 28,
  parameter int DEPTH_LOG2 = 10,
  parameter int LATENCY    = 8,
  parameter int CNT_W      = 16
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              mem_read,
  input  logic              mem_write,
  input  logic [ADDR_W-1:0] mem_addr,
  input  logic [LINE_W-1:0] mem_wdata,
  output logic [LINE_W-1:0] mem_rdata,
  output logic              mem_ready,
  output logic [CNT_W-1:0]  rd_cnt,
  output logic [CNT_W-1:0]  wr_cnt,
  output logic              proto_err
);

  localparam int DEPTH = 1 << DEPTH_LOG2;
  localparam int CW    = (LATENCY > 1) ? $clog2(LATENCY) : 1;
  localparam logic [CW-1:0] LOAD = CW'(LATENCY - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    RESP = 2'd2
  } state_t;

  state_t                r_state;
  logic [CW-1:0]         r_count;
  logic                  r_isWrite;
  logic [DEPTH_LOG2-1:0] r_idx;
  logic [LINE_W-1:0]     r_wdata;
  logic [LINE_W-1:0]     r_rdata;
  logic                  r_ready;
  logic [CNT_W-1:0]      r_rdCnt;
  logic [CNT_W-1:0]      r_wrCnt;
  logic                  r_protoErr;

  // Storage lines themselves carry no reset; a per-line valid bit cleared by
  // reset makes every line read back as zero until it is written again.
  logic [LINE_W-1:0]     r_mem [DEPTH];
  logic [DEPTH-1:0]      r_valid;

  logic                  w_commitWrite;
  logic                  w_lastBusy;
  logic                  w_unusedAddrHi;

  // Upper address bits alias onto the same storage index and are dropped.
  assign w_unusedAddrHi = &{1'b0, mem_addr[ADDR_W-1:DEPTH_LOG2]};

  assign w_lastBusy    = (r_state == BUSY) && (r_count == '0);
  assign w_commitWrite = !reset && w_lastBusy && r_isWrite;

  assign mem_rdata = r_rdata;
  assign mem_ready = r_ready;
  assign rd_cnt    = r_rdCnt;
  assign wr_cnt    = r_wrCnt;
  assign proto_err = r_protoErr;

  // Storage write port: the captured line commits at the response edge.
  always_ff @(posedge clk) begin
    if (w_commitWrite) begin
      r_mem[r_idx] <= r_wdata;
    end
  end

  // Request FSM: accept in IDLE, count down in BUSY, pulse ready in RESP.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state    <= IDLE;
      r_count    <= '0;
      r_isWrite  <= 1'b0;
      r_idx      <= '0;
      r_wdata    <= '0;
      r_rdata    <= '0;
      r_ready    <= 1'b0;
      r_rdCnt    <= '0;
      r_wrCnt    <= '0;
      r_protoErr <= 1'b0;
      r_valid    <= '0;
    end else begin
      case (r_state)
        IDLE: begin
          r_ready <= 1'b0;
          if (mem_read || mem_write) begin
            r_isWrite <= mem_write;
            r_idx     <= mem_addr[DEPTH_LOG2-1:0];
            r_wdata   <= mem_wdata;
            r_count   <= LOAD;
            r_state   <= BUSY;
            if (mem_write) begin
              r_wrCnt <= r_wrCnt + CNT_W'(1);
            end else begin
              r_rdCnt <= r_rdCnt + CNT_W'(1);
            end
            if (mem_read && mem_write) begin
              r_protoErr <= 1'b1;
            end
          end
        end
        BUSY: begin
          if (r_count == '0) begin
            r_state <= RESP;
            r_ready <= 1'b1;
            if (r_isWrite) begin
              r_valid[r_idx] <= 1'b1;
            end else begin
              r_rdata <= r_valid[r_idx] ? r_mem[r_idx] : '0;
            end
          end else begin
            r_count <= r_count - CW'(1);
          end
        end
        RESP: begin
          r_ready <= 1'b0;
          r_state <= IDLE;
        end
        default: begin
          r_ready <= 1'b0;
          r_state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_l2_mem_responder.sv
// tb_l2_mem_responder: directed checks of the L2 backing-memory responder.
// One instance runs with LATENCY=8 for the functional sequence, a second
// with LATENCY=1 for the back-to-back request spacing.
module tb_l2_mem_responder;

  logic         clk;
  logic         reset;

  logic         read8;
  logic         write8;
  logic [27:0]  addr8;
  logic [127:0] wdata8;
  logic [127:0] rdata8;
  logic         ready8;
  logic [15:0]  rdCnt8;
  logic [15:0]  wrCnt8;
  logic         err8;

  logic         read1;
  logic         write1;
  logic [27:0]  addr1;
  logic [127:0] wdata1;
  logic [127:0] rdata1;
  logic         ready1;
  logic [15:0]  rdCnt1;
  logic [15:0]  wrCnt1;
  logic         err1;

  int compCount;
  int errCount;

  localparam logic [127:0] DATA_A = 128'h0123456789ABCDEF0123456789ABCDEF;
  localparam logic [127:0] DATA_B = 128'hFEDCBA9876543210FEDCBA9876543210;
  localparam logic [127:0] DATA_C = 128'hAAAAAAAAAAAAAAAAAAAAAAAAAAAAAAAA;
  localparam logic [127:0] DATA_D = 128'h55555555555555555555555555555555;

  l2_mem_responder #(.LATENCY(8)) u_dut8 (
    .clk       (clk),
    .reset     (reset),
    .mem_read  (read8),
    .mem_write (write8),
    .mem_addr  (addr8),
    .mem_wdata (wdata8),
    .mem_rdata (rdata8),
    .mem_ready (ready8),
    .rd_cnt    (rdCnt8),
    .wr_cnt    (wrCnt8),
    .proto_err (err8)
  );

  l2_mem_responder #(.LATENCY(1)) u_dut1 (
    .clk       (clk),
    .reset     (reset),
    .mem_read  (read1),
    .mem_write (write1),
    .mem_addr  (addr1),
    .mem_wdata (wdata1),
    .mem_rdata (rdata1),
    .mem_ready (ready1),
    .rd_cnt    (rdCnt1),
    .wr_cnt    (wrCnt1),
    .proto_err (err1)
  );

  // Free-running 10 ns clock.
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Compare one observed value against its hand-computed expectation.
  task automatic checkOutput(input string tag, input logic [127:0] observed,
                             input logic [127:0] expected);
    compCount++;
    assert (observed === expected) else begin
      errCount++;
      $error("[TB] FAIL %s: observed %h expected %h", tag, observed, expected);
    end
  endtask

  // Issue one request to the LATENCY=8 instance and follow it to completion:
  // lat is the number of edges from acceptance to the ready pulse (-1 if it
  // never came), rdat the line seen during the pulse, widthOk whether ready
  // was low again one edge later.
  task automatic applyStimulus(input logic rd, input logic wr,
                               input logic [27:0] a, input logic [127:0] d,
                               output int lat, output logic [127:0] rdat,
                               output logic widthOk);
    @(negedge clk);
    read8  = rd;
    write8 = wr;
    addr8  = a;
    wdata8 = d;
    @(posedge clk);
    lat  = -1;
    rdat = '0;
    for (int n = 1; n <= 50; n++) begin
      @(posedge clk);
      #1;
      if (ready8) begin
        lat  = n;
        rdat = rdata8;
        break;
      end
    end
    read8  = 1'b0;
    write8 = 1'b0;
    @(posedge clk);
    #1;
    widthOk = !ready8;
  endtask

  int           lat;
  logic [127:0] rdat;
  logic         widthOk;
  int           pulses;
  int           gap;
  int           extra;

  // Directed sequence.
  initial begin
    compCount = 0;
    errCount  = 0;
    reset  = 1'b1;
    read8  = 1'b0;
    write8 = 1'b0;
    addr8  = '0;
    wdata8 = '0;
    read1  = 1'b0;
    write1 = 1'b0;
    addr1  = 28'h0000002;
    wdata1 = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    reset = 1'b0;

    checkOutput("reset ready", 128'(ready8), 128'd0);
    checkOutput("reset rdata", rdata8, 128'd0);
    checkOutput("reset rd_cnt", 128'(rdCnt8), 128'd0);
    checkOutput("reset wr_cnt", 128'(wrCnt8), 128'd0);
    checkOutput("reset proto_err", 128'(err8), 128'd0);

    // Read of a never-written line.
    applyStimulus(1'b1, 1'b0, 28'h0000005, '0, lat, rdat, widthOk);
    checkOutput("read5 latency", 128'(lat), 128'd8);
    checkOutput("read5 pulse width", 128'(widthOk), 128'd1);
    checkOutput("read5 rdata", rdat, 128'd0);
    checkOutput("read5 rd_cnt", 128'(rdCnt8), 128'd1);
    checkOutput("read5 wr_cnt", 128'(wrCnt8), 128'd0);

    // Write then read back the same line.
    applyStimulus(1'b0, 1'b1, 28'h0000003, DATA_A, lat, rdat, widthOk);
    checkOutput("write3 latency", 128'(lat), 128'd8);
    checkOutput("write3 pulse width", 128'(widthOk), 128'd1);
    checkOutput("write3 rdata held", rdat, 128'd0);
    checkOutput("write3 wr_cnt", 128'(wrCnt8), 128'd1);
    applyStimulus(1'b1, 1'b0, 28'h0000003, '0, lat, rdat, widthOk);
    checkOutput("read3 latency", 128'(lat), 128'd8);
    checkOutput("read3 rdata", rdat, DATA_A);
    checkOutput("read3 rd_cnt", 128'(rdCnt8), 128'd2);

    // 0x403 aliases onto index 3.
    applyStimulus(1'b0, 1'b1, 28'h0000403, DATA_B, lat, rdat, widthOk);
    applyStimulus(1'b1, 1'b0, 28'h0000003, '0, lat, rdat, widthOk);
    checkOutput("alias rdata", rdat, DATA_B);
    checkOutput("alias rd_cnt", 128'(rdCnt8), 128'd3);
    checkOutput("alias wr_cnt", 128'(wrCnt8), 128'd2);

    // Read and write together count as a write and set the sticky error.
    applyStimulus(1'b1, 1'b1, 28'h0000007, DATA_C, lat, rdat, widthOk);
    checkOutput("collide latency", 128'(lat), 128'd8);
    checkOutput("collide rdata held", rdat, DATA_B);
    checkOutput("collide wr_cnt", 128'(wrCnt8), 128'd3);
    checkOutput("collide rd_cnt", 128'(rdCnt8), 128'd3);
    checkOutput("collide proto_err", 128'(err8), 128'd1);
    applyStimulus(1'b1, 1'b0, 28'h0000007, '0, lat, rdat, widthOk);
    checkOutput("collide readback", rdat, DATA_C);
    checkOutput("proto_err sticky", 128'(err8), 128'd1);
    checkOutput("after collide rd_cnt", 128'(rdCnt8), 128'd4);

    // LATENCY=1 instance with mem_read held: each pulse is followed by two
    // low samples (RESP->IDLE edge, then the accepting edge).
    @(negedge clk);
    read1  = 1'b1;
    pulses = 0;
    gap    = 0;
    for (int n = 0; n < 40; n++) begin
      @(posedge clk);
      #1;
      if (ready1) begin
        pulses++;
        if (pulses > 1) checkOutput("b2b gap", 128'(gap), 128'd2);
        gap = 0;
        if (pulses == 3) begin
          read1 = 1'b0;
          break;
        end
      end else if (pulses > 0) begin
        gap++;
      end
    end
    extra = 0;
    for (int n = 0; n < 6; n++) begin
      @(posedge clk);
      #1;
      if (ready1) extra++;
    end
    checkOutput("b2b pulses", 128'(pulses), 128'd3);
    checkOutput("b2b no duplicate", 128'(extra), 128'd0);
    checkOutput("b2b rd_cnt", 128'(rdCnt1), 128'd3);
    checkOutput("b2b wr_cnt", 128'(wrCnt1), 128'd0);
    checkOutput("b2b rdata", rdata1, 128'd0);
    checkOutput("b2b proto_err", 128'(err1), 128'd0);

    // Reset during the fourth BUSY cycle of a write to 0x9 aborts it.
    @(negedge clk);
    write8 = 1'b1;
    addr8  = 28'h0000009;
    wdata8 = DATA_D;
    @(posedge clk);
    repeat (4) @(posedge clk);
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    reset  = 1'b0;
    write8 = 1'b0;
    extra  = 0;
    for (int n = 0; n < 12; n++) begin
      @(posedge clk);
      #1;
      if (ready8) extra++;
    end
    checkOutput("abort no pulse", 128'(extra), 128'd0);
    checkOutput("abort rd_cnt", 128'(rdCnt8), 128'd0);
    checkOutput("abort wr_cnt", 128'(wrCnt8), 128'd0);
    checkOutput("abort proto_err", 128'(err8), 128'd0);
    checkOutput("abort rdata", rdata8, 128'd0);
    applyStimulus(1'b1, 1'b0, 28'h0000009, '0, lat, rdat, widthOk);
    checkOutput("abort read9 latency", 128'(lat), 128'd8);
    checkOutput("abort read9 rdata", rdat, 128'd0);
    checkOutput("abort read9 rd_cnt", 128'(rdCnt8), 128'd1);
    applyStimulus(1'b1, 1'b0, 28'h0000003, '0, lat, rdat, widthOk);
    checkOutput("cleared line3", rdat, 128'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compCount, errCount);
    $finish;
  end

endmodule
